// File: rtl/serial_in_parallel_out.sv
// -----------------------------------------------------------------------------
// serial_in_parallel_out
//
// Serial-to-parallel shift register. One serial bit is taken on every rising
// clk edge while reset is high; the shift register contents are presented
// unchanged on parallel_out.
//
// Parameters
//   WIDTH      shift register length in bits (2..32)
//   MSB_FIRST  1: first received bit ends in parallel_out[WIDTH-1]
//              0: first received bit ends in parallel_out[0]
//
// Ports
//   clk           in   1      sole clock, rising edge
//   reset         in   1      asynchronous, active-low reset
//   serial_in     in   1      serial data bit
//   parallel_out  out  WIDTH  current shift register contents (flop outputs)
//   word_valid    out  1      one-cycle pulse after the WIDTH-th bit of a word
//
// Configuration macro
//   SIPO_WORD_VALID_EN  when defined, the bit counter and the word_valid
//                       pulse are built; when undefined, no counter exists
//                       and word_valid is tied to 0. Shifting is identical
//                       in both builds.
//
// Reset release must be synchronised to clk outside this block.
// -----------------------------------------------------------------------------
module serial_in_parallel_out #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid
);

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_next_s;

  // Next shift register value: new bit enters at the LSB end for MSB-first
  // order and at the MSB end for LSB-first order.
  always_comb begin
    shift_next_s = shift_r;
    if (MSB_FIRST) begin
      shift_next_s = {shift_r[WIDTH-2:0], serial_in};
    end else begin
      shift_next_s = {serial_in, shift_r[WIDTH-1:1]};
    end
  end

  // Shift register: shifts on every edge, no enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= {WIDTH{1'b0}};
    end else begin
      shift_r <= shift_next_s;
    end
  end

  assign parallel_out = shift_r;

`ifdef SIPO_WORD_VALID_EN
  // $clog2(WIDTH) bits always hold WIDTH-1; the wrap is an explicit compare
  // so a power-of-two WIDTH does not rely on natural overflow.
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bit_cnt_r;
  logic             word_valid_r;

  // Bit counter and word_valid pulse: the pulse is raised by the same edge
  // that samples the last bit, so it coincides with the completed word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_r    <= {CNT_W{1'b0}};
      word_valid_r <= 1'b0;
    end else if (bit_cnt_r == LAST_CNT) begin
      bit_cnt_r    <= {CNT_W{1'b0}};
      word_valid_r <= 1'b1;
    end else begin
      bit_cnt_r    <= bit_cnt_r + CNT_W'(1);
      word_valid_r <= 1'b0;
    end
  end

  assign word_valid = word_valid_r;
`else
  assign word_valid = 1'b0;
`endif

endmodule

// File: tb/tb_serial_in_parallel_out.sv
// -----------------------------------------------------------------------------
// tb_serial_in_parallel_out
//
// Self-checking bench for serial_in_parallel_out. Three instances share one
// serial stream: 4-bit MSB-first, 4-bit LSB-first and 5-bit MSB-first.
// Expected values come from a history of the bits received since the last
// reset: the k-th most recent bit must sit at position k (MSB-first) or
// WIDTH-1-k (LSB-first), and a word completes whenever the number of bits
// since reset is a non-zero multiple of WIDTH.
// -----------------------------------------------------------------------------
module tb_serial_in_parallel_out;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [3:0] po_msb4;
  logic [3:0] po_lsb4;
  logic [4:0] po_msb5;
  logic       wv_msb4;
  logic       wv_lsb4;
  logic       wv_msb5;

  int checks_cnt;
  int errors_cnt;

  // Bits received since the most recent reset, oldest first.
  bit hist_q[$];

  serial_in_parallel_out #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb4 (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .parallel_out(po_msb4), .word_valid(wv_msb4)
  );

  serial_in_parallel_out #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb4 (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .parallel_out(po_lsb4), .word_valid(wv_lsb4)
  );

  serial_in_parallel_out #(.WIDTH(5), .MSB_FIRST(1'b1)) dut_msb5 (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .parallel_out(po_msb5), .word_valid(wv_msb5)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_out(input int w, input bit msb);
    logic [31:0] v;
    int          n;
    v = 32'd0;
    n = hist_q.size();
    for (int k = 0; k < w; k++) begin
      if (k < n) begin
        if (msb) v[k] = hist_q[n-1-k];
        else     v[w-1-k] = hist_q[n-1-k];
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wv(input int w);
`ifdef SIPO_WORD_VALID_EN
    int n;
    n = hist_q.size();
    return ((n > 0) && ((n % w) == 0)) ? 32'd1 : 32'd0;
`else
    return (w > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "_po_msb4"}, 32'(po_msb4), model_out(4, 1'b1));
    check_eq({tag, "_po_lsb4"}, 32'(po_lsb4), model_out(4, 1'b0));
    check_eq({tag, "_po_msb5"}, 32'(po_msb5), model_out(5, 1'b1));
    check_eq({tag, "_wv_msb4"}, 32'(wv_msb4), model_wv(4));
    check_eq({tag, "_wv_lsb4"}, 32'(wv_lsb4), model_wv(4));
    check_eq({tag, "_wv_msb5"}, 32'(wv_msb5), model_wv(5));
  endtask

  // Drive one bit, let it be sampled, then check 1 time unit after the edge.
  task automatic step(input logic b, input string tag);
    serial_in = b;
    @(posedge clk);
    hist_q.push_back(b);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, check it takes effect at once, release on
  // the following falling edge.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    hist_q.delete();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [3:0] pat_a;
  logic [3:0] pat_b;

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset      = 1'b0;
    serial_in  = 1'b0;

    // Held in reset while clk and serial_in toggle.
    #1;
    check_all("rst_init");
    for (int i = 0; i < 3; i++) begin
      serial_in = ~serial_in;
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    @(negedge clk);
    reset = 1'b1;

    // Basic load 1,0,1,1.
    step(1'b1, "load0");
    step(1'b0, "load1");
    step(1'b1, "load2");
    step(1'b1, "load3");
    check_eq("load_msb_1011", 32'(po_msb4), 32'h0000000B);
    check_eq("load_lsb_1101", 32'(po_lsb4), 32'h0000000D);
`ifdef SIPO_WORD_VALID_EN
    check_eq("load_wv_pulse", 32'(wv_msb4), 32'd1);
`else
    check_eq("load_wv_tied0", 32'(wv_msb4), 32'd0);
`endif
    // Back-to-back words 1001 then 0110.
    pat_a = 4'b1001;
    pat_b = 4'b0110;
    for (int i = 3; i >= 0; i--) step(pat_a[i], "b2b_a");
    check_eq("b2b_word_a", 32'(po_msb4), 32'h00000009);
    for (int i = 3; i >= 0; i--) step(pat_b[i], "b2b_b");
    check_eq("b2b_word_b", 32'(po_msb4), 32'h00000006);

    // Mid-word reset after 1,1 then a fresh word 0,1,0,1.
    @(negedge clk);
    async_reset("rst_prep");
    step(1'b1, "mid0");
    step(1'b1, "mid1");
    #2;
    async_reset("mid_rst");
    check_eq("mid_rst_zero", 32'(po_msb4), 32'h00000000);
    step(1'b0, "post0");
    step(1'b1, "post1");
    step(1'b0, "post2");
    step(1'b1, "post3");
    check_eq("post_word_0101", 32'(po_msb4), 32'h00000005);

    // Random stream with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #1;
        async_reset("rnd_rst");
      end
      step(1'($urandom_range(0, 1)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/serial_in_parallel_out.md
SERIAL_IN_PARALLEL_OUT -- requirements
Module: serial_in_parallel_out

Interface
REQ-001 Parameter WIDTH, default 4: shift register length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit ends in parallel_out[WIDTH-1]; 0 = first received bit ends in parallel_out[0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset = 0 resets).
REQ-005 serial_in  input  1  serial data bit, sampled on every rising clk edge while reset = 1.
REQ-006 parallel_out  output  WIDTH  current shift register contents, driven directly from flops.
REQ-007 word_valid  output  1  one-cycle pulse: a complete WIDTH-bit word has just been assembled.

Function
REQ-008 The block SHALL shift on every rising clk edge while reset = 1; there is no enable or hold input.
REQ-009 With MSB_FIRST = 1, each edge SHALL load parallel_out <= {parallel_out[WIDTH-2:0], serial_in}.
REQ-010 With MSB_FIRST = 0, each edge SHALL load parallel_out <= {serial_in, parallel_out[WIDTH-1:1]}.
REQ-011 Latency: a bit sampled at edge N SHALL be visible on parallel_out immediately after edge N; a full word SHALL be present WIDTH edges after its first bit.
REQ-012 An internal bit counter SHALL count samples 0..WIDTH-1 and wrap to 0 after WIDTH-1.
REQ-013 The counter SHALL be sized ceil(log2(WIDTH)) bits or wider; when WIDTH is a power of two, wrap SHALL still occur exactly at WIDTH-1.
REQ-014 word_valid SHALL be registered and SHALL be 1 for exactly one clock cycle after the edge that samples the WIDTH-th bit of a word; otherwise 0.
REQ-015 While word_valid = 1, parallel_out SHALL hold the completed word.
REQ-016 Consecutive words SHALL be back-to-back: word_valid pulses every WIDTH cycles with no gap cycles.
REQ-017 serial_in values of X/Z are not handled specially; the sampled value SHALL be shifted in as-is.

Reset
REQ-018 While reset = 0, parallel_out, the bit counter and word_valid SHALL all be 0, independent of clk.
REQ-019 Assertion of reset SHALL take effect immediately (asynchronous), including mid-word; any partial word is discarded.
REQ-020 After reset is released, the first rising edge SHALL sample bit 0 of a new word (counter starts at 0).
REQ-021 Reset release SHALL be synchronised externally; the block SHALL contain no reset synchroniser.

Configuration
REQ-022 Macro SIPO_WORD_VALID_EN: when defined, the bit counter and word_valid logic (REQ-012..REQ-016) SHALL be present as specified.
REQ-023 When SIPO_WORD_VALID_EN is undefined, no counter SHALL be built.
REQ-024 When SIPO_WORD_VALID_EN is undefined, word_valid SHALL remain a port tied constantly to 0.
REQ-025 When SIPO_WORD_VALID_EN is undefined, shift behaviour SHALL be unchanged.

Verification
REQ-026 Reset check: hold reset = 0 and toggle clk and serial_in for 3 cycles -> parallel_out = 4'b0000 and word_valid = 0 throughout.
REQ-027 Basic load (WIDTH = 4, MSB_FIRST = 1, macro defined): release reset, then feed 1,0,1,1 on 4 edges -> parallel_out = 4'b1011 after edge 4, and word_valid = 1 for that one cycle only.
REQ-028 LSB-first (MSB_FIRST = 0): feed 1,0,1,1 -> parallel_out = 4'b1101 after edge 4.
REQ-029 Back-to-back words: feed 1,0,0,1 then 0,1,1,0 continuously -> 4'b1001 then 4'b0110, with word_valid pulses exactly 4 cycles apart.
REQ-030 Mid-word reset: after 2 bits (1,1), assert reset between edges -> parallel_out = 0 immediately.
REQ-031 Mid-word reset, continued: release reset and feed 0,1,0,1 -> parallel_out = 4'b0101 with word_valid on the 4th edge after release.
REQ-032 Macro undefined: repeat REQ-027 -> same parallel_out values, word_valid constantly 0.
